// File: rtl/pc_fetch_sequencer.sv
// Program-counter and fetch sequencer: linear fetch, taken-branch redirect
// with a fixed flush window, stall, and halt/resume.
module pc_fetch_sequencer #(
    parameter int unsigned bus          = 4,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           branch_taken,
    input  logic [bus-1:0] branch_target,
    input  logic           halt_req,
    input  logic           resume,
    output logic [bus-1:0] PC,
    output logic           fetch_valid,
    output logic           flush,
    output logic           halted
);

    localparam int unsigned CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        START = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } state_t;

    state_t          state, state_n;
    logic [CW-1:0]   cnt, cnt_n;
    logic [bus-1:0]  pc_n;
    logic            fetch_valid_n;
    logic            flush_n;
    logic            halted_n;

    // State and registered outputs; reset aborts any flush or halt at once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= START;
            cnt         <= '0;
            PC          <= '0;
            fetch_valid <= 1'b0;
            flush       <= 1'b0;
            halted      <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            PC          <= pc_n;
            fetch_valid <= fetch_valid_n;
            flush       <= flush_n;
            halted      <= halted_n;
        end
    end

    // Next-state and next-output decode; RUN priority is branch > halt > stall > increment
    always_comb begin
        state_n       = state;
        cnt_n         = cnt;
        pc_n          = PC;
        fetch_valid_n = fetch_valid;
        flush_n       = flush;
        halted_n      = halted;

        case (state)
            START: begin
                state_n       = RUN;
                fetch_valid_n = 1'b1;
                flush_n       = 1'b0;
                halted_n      = 1'b0;
            end
            RUN: begin
                if (branch_taken) begin
                    pc_n          = branch_target;
                    flush_n       = 1'b1;
                    fetch_valid_n = 1'b0;
                    cnt_n         = CW'(FLUSH_CYCLES - 1);
                    state_n       = FLUSH;
                end else if (halt_req) begin
                    fetch_valid_n = 1'b0;
                    halted_n      = 1'b1;
                    state_n       = HALT;
                end else if (stall) begin
                    fetch_valid_n = 1'b1;
                end else begin
                    pc_n          = PC + bus'(1);
                    fetch_valid_n = 1'b1;
                end
            end
            FLUSH: begin
                if (cnt != '0) begin
                    cnt_n = cnt - CW'(1);
                end else begin
                    flush_n       = 1'b0;
                    fetch_valid_n = 1'b1;
                    state_n       = RUN;
                end
            end
            HALT: begin
                if (resume) begin
                    halted_n      = 1'b0;
                    fetch_valid_n = 1'b1;
                    state_n       = RUN;
                end
            end
            default: begin
                state_n = START;
            end
        endcase
    end

endmodule

// File: tb/tb_pc_fetch_sequencer.sv
// Directed self-checking bench for pc_fetch_sequencer (bus=4, FLUSH_CYCLES=2).
module tb_pc_fetch_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       stall;
    logic       branch_taken;
    logic [3:0] branch_target;
    logic       halt_req;
    logic       resume;
    logic [3:0] PC;
    logic       fetch_valid;
    logic       flush;
    logic       halted;

    int passed = 0;
    int total  = 0;

    pc_fetch_sequencer #(.bus(4), .FLUSH_CYCLES(2)) dut (
        .clk           (clk),
        .rst           (rst),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .halt_req      (halt_req),
        .resume        (resume),
        .PC            (PC),
        .fetch_valid   (fetch_valid),
        .flush         (flush),
        .halted        (halted)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Compare all four outputs against expected values
    task automatic chk_all(input string tag, input logic [3:0] epc, input logic efv,
                           input logic efl, input logic eh);
        chk({tag, ".pc"}, 32'(PC), 32'(epc));
        chk({tag, ".fetch_valid"}, 32'(fetch_valid), 32'(efv));
        chk({tag, ".flush"}, 32'(flush), 32'(efl));
        chk({tag, ".halted"}, 32'(halted), 32'(eh));
    endtask

    // Advance one rising edge and settle
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 4'h0;
        halt_req      = 1'b0;
        resume        = 1'b0;

        // Reset state
        step();
        step();
        chk_all("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;

        // Scenario 1: START then linear fetch from 0
        step(); chk_all("s1_run0", 4'h0, 1'b1, 1'b0, 1'b0);
        step(); chk_all("s1_run1", 4'h1, 1'b1, 1'b0, 1'b0);
        step(); chk_all("s1_run2", 4'h2, 1'b1, 1'b0, 1'b0);

        // Scenario 2: run to E and wrap
        for (int i = 0; i < 12; i++) step();
        chk_all("s2_E", 4'hE, 1'b1, 1'b0, 1'b0);
        step(); chk_all("s2_F", 4'hF, 1'b1, 1'b0, 1'b0);
        step(); chk_all("s2_wrap0", 4'h0, 1'b1, 1'b0, 1'b0);
        step(); chk_all("s2_1", 4'h1, 1'b1, 1'b0, 1'b0);

        // Stall holds PC with fetch_valid high
        stall = 1'b1;
        step(); chk_all("stall_hold", 4'h1, 1'b1, 1'b0, 1'b0);
        stall = 1'b0;
        step(); chk_all("s3_2", 4'h2, 1'b1, 1'b0, 1'b0);
        step(); chk_all("s3_3", 4'h3, 1'b1, 1'b0, 1'b0);

        // Scenario 3: branch to A at PC=3
        branch_taken  = 1'b1;
        branch_target = 4'hA;
        step(); chk_all("s3_flush1", 4'hA, 1'b0, 1'b1, 1'b0);
        branch_taken  = 1'b0;
        branch_target = 4'h0;
        step(); chk_all("s3_flush2", 4'hA, 1'b0, 1'b1, 1'b0);
        step(); chk_all("s3_validA", 4'hA, 1'b1, 1'b0, 1'b0);
        step(); chk_all("s3_B", 4'hB, 1'b1, 1'b0, 1'b0);

        // Scenario 4: branch beats stall and halt_req
        branch_taken  = 1'b1;
        branch_target = 4'h5;
        stall         = 1'b1;
        halt_req      = 1'b1;
        step(); chk_all("s4_flush1", 4'h5, 1'b0, 1'b1, 1'b0);
        branch_taken  = 1'b0;
        stall         = 1'b0;
        halt_req      = 1'b0;
        step(); chk_all("s4_flush2", 4'h5, 1'b0, 1'b1, 1'b0);
        step(); chk_all("s4_valid5", 4'h5, 1'b1, 1'b0, 1'b0);
        step(); chk_all("s4_6", 4'h6, 1'b1, 1'b0, 1'b0);
        step(); chk_all("s4_7", 4'h7, 1'b1, 1'b0, 1'b0);

        // Scenario 5: halt at 7, branch ignored, resume beats halt_req
        halt_req = 1'b1;
        step(); chk_all("s5_halt", 4'h7, 1'b0, 1'b0, 1'b1);
        halt_req      = 1'b0;
        branch_taken  = 1'b1;
        branch_target = 4'h2;
        step(); chk_all("s5_halt_br", 4'h7, 1'b0, 1'b0, 1'b1);
        branch_taken = 1'b0;
        resume       = 1'b1;
        halt_req     = 1'b1;
        step(); chk_all("s5_resume", 4'h7, 1'b1, 1'b0, 1'b0);
        resume   = 1'b0;
        halt_req = 1'b0;
        step(); chk_all("s5_8", 4'h8, 1'b1, 1'b0, 1'b0);

        // Scenario 6: asynchronous reset one cycle into FLUSH
        branch_taken  = 1'b1;
        branch_target = 4'hC;
        step(); chk_all("s6_flush1", 4'hC, 1'b0, 1'b1, 1'b0);
        branch_taken = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all("s6_async_rst", 4'h0, 1'b0, 1'b0, 1'b0);
        step(); chk_all("s6_rst_hold", 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        step(); chk_all("s6_run0", 4'h0, 1'b1, 1'b0, 1'b0);
        step(); chk_all("s6_run1", 4'h1, 1'b1, 1'b0, 1'b0);
        step(); chk_all("s6_run2", 4'h2, 1'b1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
